digdug_busif: RTL

DIGDUG_BUSIF -- requirements
Module: digdug_busif

---
 rtl/digdug_busif.sv | 130 +++++++++++++
 1 files changed

// File: rtl/digdug_busif.sv
// Bus bridge between the main CPU and the custom I/O chips: control register,
// indexed data port with write strobe / read pass-through, and a periodic NMI.
module digdug_busif #(
  parameter int PRESC = 2400,
  parameter int NMIW  = 64
) (
  input  logic       CL,
  input  logic       RESET,
  input  logic       CPU_CS_CTRL,
  input  logic       CPU_CS_DATA,
  input  logic       CPU_WR,
  input  logic       CPU_RD,
  input  logic [7:0] CPU_DI,
  output logic [7:0] CPU_DO,
  output logic       CPU_NMI_N,
  output logic [3:0] IO_CS,
  output logic       IO_WR,
  output logic [4:0] IO_AD,
  output logic [7:0] IO_DO,
  input  logic [7:0] IO_DI
);

  // The longest period is 8 units; the timer must hold up to 8*PRESC-1.
  localparam int              TW      = $clog2(8 * PRESC);
  localparam logic [31:0]     PRESC_U = 32'(PRESC);
  localparam logic [TW-1:0]   NMIW_T  = TW'(NMIW);

  logic [7:0]    ctrl;
  logic [3:0]    idx;
  logic          cmdpend;
  logic          wr_q, rd_q, ctl_q;
  logic          io_wr;
  logic [4:0]    strobe_ad;
  logic [7:0]    io_do;
  logic [TW-1:0] timer;
  logic          done;
  logic          nmi_n;

  logic          data_wr, data_rd, ctrl_wr;
  logic          ctrl_edge, wr_edge, rd_edge;
  logic          chip_en, wr_en, rd_en;
  logic [TW-1:0] period_m1, timer_nx;
  logic          timer_wrap, done_nx;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    data_wr    = CPU_CS_DATA & CPU_WR;
    data_rd    = CPU_CS_DATA & CPU_RD;
    ctrl_wr    = CPU_CS_CTRL & CPU_WR;
    // A control write in the same cycle swallows any data-port access.
    ctrl_edge  = ctrl_wr & ~ctl_q;
    wr_edge    = data_wr & ~wr_q & ~ctrl_edge;
    rd_edge    = data_rd & ~rd_q & ~ctrl_edge;
    chip_en    = |ctrl[3:0];
    wr_en      = chip_en & ~ctrl[4];
    rd_en      = chip_en & ctrl[4];
    period_m1  = TW'((32'(ctrl[7:5]) + 32'd1) * PRESC_U - 32'd1);
    timer_wrap = (timer == period_m1);
    timer_nx   = timer_wrap ? '0 : timer + TW'(1);
    done_nx    = done | timer_wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      ctrl      <= '0;
      idx       <= '0;
      cmdpend   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ctl_q     <= 1'b0;
      io_wr     <= 1'b0;
      strobe_ad <= '0;
      io_do     <= '0;
      timer     <= '0;
      done      <= 1'b0;
      nmi_n     <= 1'b1;
    end else begin
      wr_q  <= data_wr;
      rd_q  <= data_rd;
      ctl_q <= ctrl_wr;
      io_wr <= 1'b0;

      if (ctrl_edge) begin
        ctrl    <= CPU_DI;
        idx     <= '0;
        cmdpend <= 1'b1;
      end else if (wr_edge && wr_en) begin
        io_wr <= 1'b1;
        io_do <= CPU_DI;
        if (cmdpend) begin
          strobe_ad <= 5'h10;
          cmdpend   <= 1'b0;
        end else begin
          strobe_ad <= {1'b0, idx};
          idx       <= idx + 4'd1;
        end
      end else if (rd_edge && rd_en) begin
        idx     <= idx + 4'd1;
        cmdpend <= 1'b0;
      end

      // NMI output is computed from next-state values so it is aligned
      // with the timer wrap rather than lagging it by a cycle.
      if (ctrl_edge) begin
        timer <= '0;
        done  <= 1'b0;
        nmi_n <= 1'b1;
      end else if (!chip_en) begin
        timer <= '0;
        nmi_n <= 1'b1;
      end else begin
        timer <= timer_nx;
        done  <= done_nx;
        nmi_n <= ~(done_nx && (timer_nx < NMIW_T));
      end
    end
  end

  assign IO_CS     = ctrl[3:0];
  assign IO_WR     = io_wr;
  assign IO_AD     = io_wr ? strobe_ad : {cmdpend, idx};
  assign IO_DO     = io_do;
  assign CPU_NMI_N = nmi_n;
  assign CPU_DO    = CPU_CS_CTRL            ? ctrl  :
                     (CPU_CS_DATA && rd_en) ? IO_DI : 8'hFF;

endmodule
